// File: rtl/nco_pkg.sv
// Shared types and elaboration-time helpers for the multi-waveform NCO.
// The quarter-wave table is computed here so every LUT size comes from one formula.
package nco_pkg;

    typedef enum logic [1:0] {
        SINE   = 2'b00,
        TRI    = 2'b01,
        SAW    = 2'b10,
        SQUARE = 2'b11
    } nco_mode_e;

    localparam real NCO_PI = 3.14159265358979323846;

    // Largest positive amplitude; the most-negative code is never produced by sine/square.
    function automatic int nco_peak(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

    function automatic int nco_lut_entry(input int k, input int out_w, input int lut_aw);
        real amp;
        amp = real'(nco_peak(out_w)) * $sin(NCO_PI / 2.0 * real'(k) / real'(1 << lut_aw));
        return $rtoi(amp + 0.5);
    endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// Quarter-wave sine magnitude table: address k maps to round(PEAK*sin(pi/2*k/2^LUT_AW)).
// Purely combinational; contents are fixed at elaboration.
module nco_quarter_lut
    import nco_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int LUT_AW = 6
) (
    input  logic [LUT_AW-1:0] addr,
    output logic [OUT_W-2:0]  mag
);

    localparam int N = 1 << LUT_AW;

    logic [OUT_W-2:0] rom [N];

    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam logic [OUT_W-2:0] ENTRY = (OUT_W-1)'(nco_lut_entry(k, OUT_W, LUT_AW));
        assign rom[k] = ENTRY;
    end

    assign mag = rom[addr];

endmodule

// File: rtl/nco_multi.sv
// Multi-waveform NCO: phase accumulator with wrap-aligned frequency updates, phase offset,
// and a two-stage pipeline producing sine, triangle, sawtooth or square samples.
module nco_multi
    import nco_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 16,
    parameter int LUT_AW  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [PHASE_W-1:0]      freq_in,
    input  logic                    freq_load,
    input  logic [PHASE_W-1:0]      phase_off,
    input  logic [1:0]              mode,
    input  logic                    phase_sync,
    output logic [PHASE_W-1:0]      phase,
    output logic signed [OUT_W-1:0] wave_out,
    output logic                    out_valid,
    output logic                    wrap
);

    // Stage 1 keeps only the phase bits any waveform needs.
    localparam int TOP_W = (OUT_W + 1 > LUT_AW + 2) ? OUT_W + 1 : LUT_AW + 2;
    localparam int LO_W  = PHASE_W - TOP_W;
    localparam logic [OUT_W-2:0] PEAK_MAG = (OUT_W-1)'(nco_peak(OUT_W));

    function automatic logic signed [OUT_W-1:0] apply_sign(input logic [OUT_W-2:0] mag,
                                                           input logic neg);
        logic signed [OUT_W-1:0] v;
        v = signed'({1'b0, mag});
        return neg ? -v : v;
    endfunction

    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [PHASE_W-1:0]      freq_cur_q, freq_cur_d;
    logic [PHASE_W-1:0]      freq_pend_q, freq_pend_d;
    logic                    pend_q, pend_d;
    logic                    wrap_q, wrap_d;
    logic [PHASE_W:0]        acc_sum;
    logic                    apply_freq;

    logic [TOP_W-1:0]        top_p1_q, top_p1_d;
    nco_mode_e               mode_p1_q, mode_p1_d;
    logic                    vld_p1_q, vld_p1_d;
    logic                    lo_carry;

    logic signed [OUT_W-1:0] wave_p2_q, wave_p2_d;
    logic                    vld_p2_q, vld_p2_d;

    logic [1:0]              quad;
    logic [LUT_AW-1:0]       lut_idx, lut_addr;
    logic [OUT_W-2:0]        lut_mag, sine_mag;
    logic [OUT_W-1:0]        tri_s;
    logic signed [OUT_W-1:0] sample;

    // Accumulator and staged frequency control
    always_comb begin
        acc_sum     = {1'b0, phase_q} + {1'b0, freq_cur_q};
        phase_d     = phase_q;
        freq_cur_d  = freq_cur_q;
        freq_pend_d = freq_pend_q;
        pend_d      = pend_q;
        wrap_d      = 1'b0;
        apply_freq  = 1'b0;
        if (phase_sync) begin
            phase_d    = '0;
            apply_freq = pend_q;
        end else if (en) begin
            phase_d    = acc_sum[PHASE_W-1:0];
            wrap_d     = acc_sum[PHASE_W];
            // A zero frequency never wraps, so a pending word must not wait for one.
            apply_freq = pend_q && (acc_sum[PHASE_W] || (freq_cur_q == '0));
        end
        if (apply_freq) begin
            freq_cur_d = freq_pend_q;
            pend_d     = 1'b0;
        end
        if (freq_load) begin
            freq_pend_d = freq_in;
            pend_d      = 1'b1;
        end
    end

    // Stage 1: offset phase, keep top bits, mode and valid
    always_comb begin
        lo_carry  = phase_off[LO_W-1:0] > ~phase_q[LO_W-1:0];
        top_p1_d  = top_p1_q;
        mode_p1_d = mode_p1_q;
        vld_p1_d  = vld_p1_q;
        if (en) begin
            top_p1_d  = phase_q[PHASE_W-1 -: TOP_W] + phase_off[PHASE_W-1 -: TOP_W]
                      + TOP_W'(lo_carry);
            mode_p1_d = nco_mode_e'(mode);
            vld_p1_d  = 1'b1;
        end
    end

    nco_quarter_lut #(
        .OUT_W  (OUT_W),
        .LUT_AW (LUT_AW)
    ) u_lut (
        .addr (lut_addr),
        .mag  (lut_mag)
    );

    // Stage 2: waveform synthesis
    always_comb begin
        quad     = top_p1_q[TOP_W-1 -: 2];
        lut_idx  = top_p1_q[TOP_W-3 -: LUT_AW];
        lut_addr = quad[0] ? ({LUT_AW{1'b0}} - lut_idx) : lut_idx;
        sine_mag = (quad[0] && (lut_idx == '0)) ? PEAK_MAG : lut_mag;
        tri_s    = top_p1_q[TOP_W-2 -: OUT_W];
        sample   = '0;
        case (mode_p1_q)
            SINE:    sample = apply_sign(sine_mag, quad[1]);
            TRI:     sample = signed'((quad == 2'b01 || quad == 2'b10) ? ~tri_s : tri_s);
            SAW:     sample = signed'(top_p1_q[TOP_W-1 -: OUT_W]);
            SQUARE:  sample = apply_sign(PEAK_MAG, quad[1]);
            default: sample = '0;
        endcase
        wave_p2_d = wave_p2_q;
        vld_p2_d  = vld_p2_q;
        if (en) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                wave_p2_d = sample;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= '0;
            freq_cur_q  <= '0;
            freq_pend_q <= '0;
            pend_q      <= 1'b0;
            wrap_q      <= 1'b0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            wave_p2_q   <= '0;
        end else begin
            phase_q     <= phase_d;
            freq_cur_q  <= freq_cur_d;
            freq_pend_q <= freq_pend_d;
            pend_q      <= pend_d;
            wrap_q      <= wrap_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            wave_p2_q   <= wave_p2_d;
        end
    end

    // Stage-1 data is qualified by vld_p1_q, so it needs no reset.
    always_ff @(posedge clk) begin
        top_p1_q  <= top_p1_d;
        mode_p1_q <= mode_p1_d;
    end

    assign phase     = phase_q;
    assign wave_out  = wave_p2_q;
    assign out_valid = vld_p2_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_nco_multi.sv
// Bench for nco_multi: default build plus an OUT_W=12/LUT_AW=8 build sharing the same stimulus,
// both checked against an arithmetic model of phase, frequency staging and waveform shapes.
module tb_nco_multi;

    localparam int PW  = 32;
    localparam int OW  = 16;
    localparam int LA  = 6;
    localparam int OW2 = 12;
    localparam int LA2 = 8;
    localparam longint unsigned MASK = 64'hFFFF_FFFF;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0, en = 1'b0, freq_load = 1'b0, phase_sync = 1'b0;
    logic [31:0] freq_in = '0, phase_off = '0;
    logic [1:0]  mode = 2'b00;

    logic [31:0]        phase, phase2;
    logic signed [15:0] wave_out;
    logic signed [11:0] wave2;
    logic               out_valid, wrap, valid2, wrap2;

    nco_multi #(.PHASE_W(PW), .OUT_W(OW), .LUT_AW(LA)) dut (
        .clk(clk), .rst(rst), .en(en), .freq_in(freq_in), .freq_load(freq_load),
        .phase_off(phase_off), .mode(mode), .phase_sync(phase_sync),
        .phase(phase), .wave_out(wave_out), .out_valid(out_valid), .wrap(wrap)
    );

    nco_multi #(.PHASE_W(PW), .OUT_W(OW2), .LUT_AW(LA2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .freq_in(freq_in), .freq_load(freq_load),
        .phase_off(phase_off), .mode(mode), .phase_sync(phase_sync),
        .phase(phase2), .wave_out(wave2), .out_valid(valid2), .wrap(wrap2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    longint unsigned m_phase, m_fcur, m_fpend, m_p1, m_p2;
    bit              m_pend, m_wrap, m_v1, m_v2;
    int              m_mode1, m_mode2;

    logic [15:0] s1 [0:255];
    logic [11:0] s2 [0:255];

    // Ideal waveform value at phase p for an (ow, la) build.
    function automatic longint exp_sample(input longint unsigned p, input int md,
                                          input int ow, input int la);
        longint peak, n, q, pos, k, f, mag, u, mk;
        peak = (longint'(1) << (ow - 1)) - 1;
        n    = longint'(1) << la;
        q    = longint'((p >> (PW - 2)) & 3);
        mk   = (longint'(1) << ow) - 1;
        case (md)
            0: begin
                pos = longint'((p >> (PW - 2 - la)) & longint'(4 * n - 1));
                k   = pos % n;
                f   = (q % 2 == 1) ? n - k : k;
                mag = longint'($rtoi(real'(peak) * $sin(PI / 2.0 * real'(f) / real'(n)) + 0.5));
                return (q >= 2) ? -mag : mag;
            end
            1: begin
                u = longint'(p >> (PW - 1 - ow)) & mk;
                if (q == 1 || q == 2) u = u ^ mk;
                return (u > peak) ? u - (mk + 1) : u;
            end
            2: begin
                u = longint'(p >> (PW - ow)) & mk;
                return (u > peak) ? u - (mk + 1) : u;
            end
            default: return (q >= 2) ? -peak : peak;
        endcase
    endfunction

    function automatic logic [15:0] exp_w1();
        return m_v2 ? 16'(exp_sample(m_p2, m_mode2, OW, LA)) : 16'h0;
    endfunction

    function automatic logic [11:0] exp_w2();
        return m_v2 ? 12'(exp_sample(m_p2, m_mode2, OW2, LA2)) : 12'h0;
    endfunction

    task automatic step();
        longint unsigned s;
        bit carry, apply;
        if (rst) begin
            m_phase = 0; m_fcur = 0; m_fpend = 0; m_pend = 0; m_wrap = 0; m_v1 = 0; m_v2 = 0;
        end else begin
            s     = m_phase + m_fcur;
            carry = (s >> 32) != 0;
            apply = 0;
            if (en) begin
                if (m_v1) begin m_p2 = m_p1; m_mode2 = m_mode1; m_v2 = 1; end
                m_p1 = (m_phase + phase_off) & MASK; m_mode1 = int'(mode); m_v1 = 1;
            end
            m_wrap = 0;
            if (phase_sync) begin
                m_phase = 0; apply = m_pend;
            end else if (en) begin
                m_phase = s & MASK; m_wrap = carry;
                apply = m_pend && (carry || m_fcur == 0);
            end
            if (apply) begin m_fcur = m_fpend; m_pend = 0; end
            if (freq_load) begin m_fpend = freq_in; m_pend = 1; end
        end
        @(posedge clk);
        #1;
        freq_load  = 1'b0;
        phase_sync = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Install freq f as current frequency with phase at 0, enable left high.
    task automatic start(input logic [31:0] f);
        en = 1'b0; freq_in = f; freq_load = 1'b1;
        step();
        phase_sync = 1'b1;
        step();
        en = 1'b1;
    endtask

    task automatic test_reset();
        freq_in = '0; phase_off = '0; mode = 2'b00;
        do_reset();
        n_checks++; if (phase !== 32'h0) $display("FAIL reset_phase got %h want 0", phase); else n_pass++;
        n_checks++; if (wave_out !== 16'h0) $display("FAIL reset_wave got %h want 0", wave_out); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (wrap !== 1'b0) $display("FAIL reset_wrap got %b want 0", wrap); else n_pass++;
        n_checks++; if (wave2 !== 12'h0) $display("FAIL reset_wave2 got %h want 0", wave2); else n_pass++;
    endtask

    task automatic test_sine();
        int first_wrap, n_wrap;
        first_wrap = -1; n_wrap = 0;
        do_reset(); mode = 2'b00; phase_off = '0;
        start(32'h0400_0000);
        for (int j = 1; j <= 140; j++) begin
            step();
            n_checks++; if (phase !== 32'(m_phase)) $display("FAIL sine_phase j=%0d got %h want %h", j, phase, 32'(m_phase)); else n_pass++;
            n_checks++; if (wave_out !== exp_w1()) $display("FAIL sine_wave j=%0d got %h want %h", j, wave_out, exp_w1()); else n_pass++;
            n_checks++; if (wave2 !== exp_w2()) $display("FAIL sine_wave2 j=%0d got %h want %h", j, wave2, exp_w2()); else n_pass++;
            n_checks++; if (wrap !== m_wrap) $display("FAIL sine_wrap j=%0d got %b want %b", j, wrap, m_wrap); else n_pass++;
            n_checks++; if (out_valid !== m_v2) $display("FAIL sine_valid j=%0d got %b want %b", j, out_valid, m_v2); else n_pass++;
            if (j >= 2) begin s1[j-2] = wave_out; s2[j-2] = wave2; end
            if (wrap === 1'b1) begin n_wrap++; if (first_wrap < 0) first_wrap = j; end
        end
        n_checks++; if (s1[0]  !== 16'h0000) $display("FAIL sine_s0 got %h want 0000", s1[0]); else n_pass++;
        n_checks++; if (s1[1]  !== 16'h0C8C) $display("FAIL sine_s1 got %h want 0c8c", s1[1]); else n_pass++;
        n_checks++; if (s1[4]  !== 16'h30FB) $display("FAIL sine_s4 got %h want 30fb", s1[4]); else n_pass++;
        n_checks++; if (s1[16] !== 16'h7FFF) $display("FAIL sine_s16 got %h want 7fff", s1[16]); else n_pass++;
        n_checks++; if (s1[32] !== 16'h0000) $display("FAIL sine_s32 got %h want 0000", s1[32]); else n_pass++;
        n_checks++; if (s1[48] !== 16'h8001) $display("FAIL sine_s48 got %h want 8001", s1[48]); else n_pass++;
        n_checks++; if (s1[64] !== 16'h0000) $display("FAIL sine_s64 got %h want 0000", s1[64]); else n_pass++;
        n_checks++; if (s2[16] !== 12'h7FF) $display("FAIL sine12_peak got %h want 7ff", s2[16]); else n_pass++;
        n_checks++; if (s2[48] !== 12'h801) $display("FAIL sine12_trough got %h want 801", s2[48]); else n_pass++;
        n_checks++; if (first_wrap != 64) $display("FAIL sine_first_wrap got %0d want 64", first_wrap); else n_pass++;
        n_checks++; if (n_wrap != 2) $display("FAIL sine_wrap_count got %0d want 2", n_wrap); else n_pass++;
    endtask

    task automatic test_staged();
        int wraps [$];
        logic [31:0] ph65;
        do_reset(); mode = 2'b00; phase_off = '0;
        start(32'h0400_0000);
        ph65 = '0;
        for (int j = 1; j <= 140; j++) begin
            if (j == 10) begin freq_in = 32'h0800_0000; freq_load = 1'b1; end
            step();
            n_checks++; if (phase !== 32'(m_phase)) $display("FAIL staged_phase j=%0d got %h want %h", j, phase, 32'(m_phase)); else n_pass++;
            n_checks++; if (wave_out !== exp_w1()) $display("FAIL staged_wave j=%0d got %h want %h", j, wave_out, exp_w1()); else n_pass++;
            if (wrap === 1'b1) wraps.push_back(j);
            if (j == 65) ph65 = phase;
        end
        n_checks++; if (ph65 !== 32'h0800_0000) $display("FAIL staged_newfreq got %h want 08000000", ph65); else n_pass++;
        n_checks++;
        if (wraps.size() < 3 || wraps[0] != 64 || wraps[1] != 96 || wraps[2] != 128)
            $display("FAIL staged_wraps got %p want 64,96,128,...", wraps);
        else n_pass++;
    endtask

    task automatic test_offset();
        do_reset(); mode = 2'b00; phase_off = 32'h4000_0000;
        start(32'h0400_0000);
        for (int j = 1; j <= 20; j++) begin
            step();
            n_checks++; if (wave_out !== exp_w1()) $display("FAIL cos_wave j=%0d got %h want %h", j, wave_out, exp_w1()); else n_pass++;
            if (j >= 2) s1[j-2] = wave_out;
        end
        n_checks++; if (s1[0] !== 16'h7FFF) $display("FAIL cos_first got %h want 7fff", s1[0]); else n_pass++;
        do_reset(); phase_off = 32'h8000_0000;
        start(32'h0400_0000);
        for (int j = 1; j <= 20; j++) begin
            step();
            n_checks++; if (wave_out !== exp_w1()) $display("FAIL negsin_wave j=%0d got %h want %h", j, wave_out, exp_w1()); else n_pass++;
            if (j >= 2) s1[j-2] = wave_out;
        end
        n_checks++; if (s1[4] !== 16'hCF05) $display("FAIL negsin_s4 got %h want cf05", s1[4]); else n_pass++;
        n_checks++; if (s1[16] !== 16'h8001) $display("FAIL negsin_s16 got %h want 8001", s1[16]); else n_pass++;
        phase_off = '0;
    endtask

    task automatic test_modes();
        for (int md = 1; md <= 3; md++) begin
            do_reset(); mode = 2'(md); phase_off = '0;
            start(32'h1000_0000);
            for (int j = 1; j <= 18; j++) begin
                step();
                n_checks++; if (wave_out !== exp_w1()) $display("FAIL mode%0d_wave j=%0d got %h want %h", md, j, wave_out, exp_w1()); else n_pass++;
                n_checks++; if (wave2 !== exp_w2()) $display("FAIL mode%0d_wave2 j=%0d got %h want %h", md, j, wave2, exp_w2()); else n_pass++;
                if (j >= 2) s1[j-2] = wave_out;
            end
            if (md == 1) begin
                n_checks++; if (s1[0]  !== 16'h0000) $display("FAIL tri_s0 got %h want 0000", s1[0]); else n_pass++;
                n_checks++; if (s1[4]  !== 16'h7FFF) $display("FAIL tri_s4 got %h want 7fff", s1[4]); else n_pass++;
                n_checks++; if (s1[12] !== 16'h8000) $display("FAIL tri_s12 got %h want 8000", s1[12]); else n_pass++;
            end else if (md == 2) begin
                n_checks++; if (s1[0] !== 16'h0000) $display("FAIL saw_s0 got %h want 0000", s1[0]); else n_pass++;
                n_checks++; if (s1[8] !== 16'h8000) $display("FAIL saw_s8 got %h want 8000", s1[8]); else n_pass++;
            end else begin
                for (int k = 0; k < 16; k++) begin
                    n_checks++;
                    if (s1[k] !== ((k < 8) ? 16'h7FFF : 16'h8001))
                        $display("FAIL square_s%0d got %h want %h", k, s1[k], (k < 8) ? 16'h7FFF : 16'h8001);
                    else n_pass++;
                end
            end
        end
        mode = 2'b00;
    endtask

    task automatic test_control();
        logic [31:0] sp, prev;
        logic [15:0] sw;
        logic        sv;
        int          guard;
        do_reset(); mode = 2'b00;
        start(32'h0400_0000);
        for (int j = 0; j < 10; j++) step();
        sp = phase; sw = wave_out; sv = out_valid;
        en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            n_checks++; if (phase !== sp) $display("FAIL hold_phase got %h want %h", phase, sp); else n_pass++;
            n_checks++; if (wave_out !== sw) $display("FAIL hold_wave got %h want %h", wave_out, sw); else n_pass++;
            n_checks++; if (out_valid !== sv) $display("FAIL hold_valid got %b want %b", out_valid, sv); else n_pass++;
            n_checks++; if (wrap !== 1'b0) $display("FAIL hold_wrap got %b want 0", wrap); else n_pass++;
        end
        en = 1'b1;
        freq_in = 32'h0800_0000; freq_load = 1'b1;
        step();
        phase_sync = 1'b1;
        step();
        n_checks++; if (phase !== 32'h0) $display("FAIL sync_phase got %h want 0", phase); else n_pass++;
        step();
        n_checks++; if (phase !== 32'h0800_0000) $display("FAIL sync_newfreq got %h want 08000000", phase); else n_pass++;
        // Load on the very cycle the accumulator wraps.
        guard = 0;
        while (((m_phase + m_fcur) >> 32) == 0 && guard < 100) begin step(); guard++; end
        n_checks++; if (guard >= 100) $display("FAIL wrapload_timeout got %0d cycles want <100", guard); else n_pass++;
        freq_in = 32'h0200_0000; freq_load = 1'b1;
        step();
        n_checks++; if (wrap !== 1'b1) $display("FAIL wrapload_wrap got %b want 1", wrap); else n_pass++;
        prev = phase;
        step();
        n_checks++; if (phase - prev !== 32'h0800_0000) $display("FAIL wrapload_oldfreq got %h want 08000000", phase - prev); else n_pass++;
        guard = 0;
        while (wrap !== 1'b1 && guard < 100) begin step(); guard++; end
        n_checks++; if (guard >= 100) $display("FAIL wrapload_timeout2 got %0d cycles want <100", guard); else n_pass++;
        prev = phase;
        step();
        n_checks++; if (phase - prev !== 32'h0200_0000) $display("FAIL wrapload_newfreq got %h want 02000000", phase - prev); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int j = 0; j < 3000; j++) begin
            en = ($urandom % 8) != 0;
            if ($urandom % 16 == 0) begin freq_in = $urandom >> ($urandom % 8); freq_load = 1'b1; end
            phase_sync = ($urandom % 50) == 0;
            if ($urandom % 20 == 0) mode = 2'($urandom % 4);
            if ($urandom % 30 == 0) phase_off = $urandom;
            rst = ($urandom % 500) == 0;
            step();
            rst = 1'b0;
            n_checks++; if (phase !== 32'(m_phase)) $display("FAIL rnd_phase j=%0d got %h want %h", j, phase, 32'(m_phase)); else n_pass++;
            n_checks++; if (wave_out !== exp_w1()) $display("FAIL rnd_wave j=%0d got %h want %h", j, wave_out, exp_w1()); else n_pass++;
            n_checks++; if (wave2 !== exp_w2()) $display("FAIL rnd_wave2 j=%0d got %h want %h", j, wave2, exp_w2()); else n_pass++;
            n_checks++; if (out_valid !== m_v2) $display("FAIL rnd_valid j=%0d got %b want %b", j, out_valid, m_v2); else n_pass++;
            n_checks++; if (wrap !== m_wrap) $display("FAIL rnd_wrap j=%0d got %b want %b", j, wrap, m_wrap); else n_pass++;
        end
        mode = 2'b00; phase_off = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        start(32'h0400_0000);
        for (int j = 0; j < 30; j++) step();
        freq_in = 32'h0800_0000; freq_load = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (phase !== 32'h0) $display("FAIL rstmid_phase got %h want 0", phase); else n_pass++;
        n_checks++; if (wave_out !== 16'h0) $display("FAIL rstmid_wave got %h want 0", wave_out); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (wrap !== 1'b0) $display("FAIL rstmid_wrap got %b want 0", wrap); else n_pass++;
        en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            n_checks++; if (phase !== 32'h0) $display("FAIL rstmid_freq0 j=%0d got %h want 0", j, phase); else n_pass++;
        end
        n_checks++; if (out_valid !== 1'b1) $display("FAIL rstmid_valid_rise got %b want 1", out_valid); else n_pass++;
    endtask

    initial begin
        m_phase = 0; m_fcur = 0; m_fpend = 0; m_pend = 0; m_wrap = 0;
        m_p1 = 0; m_p2 = 0; m_mode1 = 0; m_mode2 = 0; m_v1 = 0; m_v2 = 0;
        test_reset();
        test_sine();
        test_staged();
        test_offset();
        test_modes();
        test_control();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
